mod_exp_ctrl: RTL and testbench
===============================

Name: mod_exp_ctrl

Overview:
- Sequencer that computes z = msg^exp mod m by repeatedly driving one external Montgomery multiplier, mod_mul (z = x*y*R^-1 mod m, R = 2^K).
- Sits above mod_mul in the RSA datapath.
- Converts msg into the Montgomery domain, runs left-to-right square-and-multiply over every exponent bit, then converts the result back.
- Owns the multiplier's operand buses and its level-held start/done handshake.

Parameters:
K, 192, operand/modulus width; must equal the mod_mul k.
E_BITS, 192, exponent width.
LOGE, 8, counter width; must satisfy 2^LOGE > E_BITS.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
msg  input  K  base, must be < m; captured when start is accepted
exp  input  E_BITS  exponent; captured when start is accepted
r2  input  K  R^2 mod m; captured when start is accepted
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse when result is valid
result  output  K  msg^exp mod m; held until the next acceptance
mm_x  output  K  multiplier operand x
mm_y  output  K  multiplier operand y
mm_start  output  1  multiplier start, level-held
mm_z  input  K  multiplier result
mm_done  input  1  multiplier done, level

Behaviour:
- Reset is asynchronous and active-low. On reset the controller enters IDLE and drives busy=0, done=0, result=0, mm_start=0, mm_x=0, mm_y=0. Internal registers reset as well.
- Acceptance: start=1 in IDLE latches msg, exp and r2, and moves to TO_M_X. start is ignored in every other state.
- Operation sequence, one multiplier op per state:
  - TO_M_X: xbar = MM(msg, r2).
  - TO_M_A: acc = MM(r2, 1), which equals R mod m.
  - SQR: acc = MM(acc, acc).
  - MUL: entered only if exp[i]=1; acc = MM(acc, xbar).
  - FROM_M: result = MM(acc, 1).
  - DONE: for one cycle.
  - Then IDLE.
- Bit index i starts at E_BITS-1. After each SQR (when exp[i]=0) or each MUL, i decrements; the step after i=0 goes to FROM_M.
- No leading-zero skip: all E_BITS bits are processed.
- Per-op handshake:
  - ISSUE phase: mm_x/mm_y are stable and mm_start=1, held until mm_done=1 is sampled. In that cycle mm_z is captured into the destination register.
  - RELEASE phase: mm_start=0 until mm_done=0 is sampled; then advance to the next op state.
  - mm_x/mm_y must not change while mm_start=1 or mm_done=1.
  - Because mm_done can be high for several cycles, exactly one capture is made per op.
- Op count = 3 + E_BITS + popcount(exp). Controller overhead is 2 cycles per op beyond multiplier latency.
- done is a 1-cycle pulse in the DONE state. result is updated in the same cycle done rises, and busy falls in that cycle.
- Boundaries:
  - exp=0: result = 1 mod m.
  - msg=0, exp!=0: result = 0.
  - start held high continuously: a new run begins the cycle after DONE returns to IDLE.
  - Inputs changing while busy have no effect.
- Reset mid-operation: everything returns to reset values and mm_start drops asynchronously. The multiplier shares rst_n, so there is no stale handshake. result is cleared.
- Width rules: all operands are K bits. The constant 1 is zero-extended to K bits. mm_z < m is guaranteed by the multiplier and is not re-reduced.

Test Plan:
(Bench: mod_mul with k=8 and m=239, controller with K=E_BITS=8, r2=50.)
- msg=5, exp=3 -> done pulse, result=125; exactly 3+8+2=13 mm_start rising edges; busy high throughout the run.
- msg=2, exp=10 -> result=68; msg=238, exp=2 -> result=1.
- exp=0, msg=77 -> result=1; msg=0, exp=5 -> result=0.
- Hold start=1 across two runs with inputs changed while busy -> the first result uses the latched inputs; the second run starts the cycle after done.
- Stretch mm_done high for 4 cycles via a stall model -> one capture per op; mm_x/mm_y are stable while mm_start or mm_done is high; result is unchanged from the unstalled run.
- Assert rst_n=0 during a SQR op -> mm_start, busy, done and result go to 0 immediately; a fresh start after release gives the correct result (5^3 -> 125).

Source files
------------

// File: rtl/mod_exp_ctrl.sv
// ---------------------------------------------------------------------------
// mod_exp_ctrl : left-to-right square-and-multiply sequencer driving mod_mul
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod_exp_ctrl #(
  parameter int K      = 192,
  parameter int E_BITS = 192,
  parameter int LOGE   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K-1:0]      msg,
  input  logic [E_BITS-1:0] exp,
  input  logic [K-1:0]      r2,
  output logic              busy,
  output logic              done,
  output logic [K-1:0]      result,
  output logic [K-1:0]      mm_x,
  output logic [K-1:0]      mm_y,
  output logic              mm_start,
  input  logic [K-1:0]      mm_z,
  input  logic              mm_done
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_to_m_x = 3'd1;
  localparam logic [2:0] c_st_to_m_a = 3'd2;
  localparam logic [2:0] c_st_sqr    = 3'd3;
  localparam logic [2:0] c_st_mul    = 3'd4;
  localparam logic [2:0] c_st_from_m = 3'd5;
  localparam logic [2:0] c_st_done   = 3'd6;

  localparam logic [K-1:0] c_one = {{(K-1){1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic              r_release;
  logic [E_BITS-1:0] r_exp;
  logic [LOGE-1:0]   r_cnt;
  logic [K-1:0]      r_r2;
  logic [K-1:0]      r_xbar;
  logic [K-1:0]      r_acc;
  logic [K-1:0]      r_result;
  logic              r_busy;
  logic              r_done;
  logic [K-1:0]      r_mm_x;
  logic [K-1:0]      r_mm_y;
  logic              r_mm_start;

  logic [2:0]   w_next_state;
  logic [K-1:0] w_next_x;
  logic [K-1:0] w_next_y;
  logic         w_step;
  logic         w_bit;
  logic         w_last;

  // The exponent is shifted left as bits are consumed, so the current bit is always the MSB.
  assign w_bit  = r_exp[E_BITS-1];
  assign w_last = (r_cnt == '0);

  always_comb begin
    w_next_state = c_st_idle;
    w_next_x     = r_acc;
    w_next_y     = c_one;
    w_step       = 1'b0;
    case (r_state)
      c_st_to_m_x: begin
        w_next_state = c_st_to_m_a;
        w_next_x     = r_r2;
      end
      c_st_to_m_a: begin
        w_next_state = c_st_sqr;
        w_next_y     = r_acc;
      end
      c_st_sqr: begin
        if (w_bit) begin
          w_next_state = c_st_mul;
          w_next_y     = r_xbar;
        end else begin
          w_step = 1'b1;
          if (w_last) begin
            w_next_state = c_st_from_m;
          end else begin
            w_next_state = c_st_sqr;
            w_next_y     = r_acc;
          end
        end
      end
      c_st_mul: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next_state = c_st_from_m;
        end else begin
          w_next_state = c_st_sqr;
          w_next_y     = r_acc;
        end
      end
      c_st_from_m: w_next_state = c_st_done;
      default:     w_next_state = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_release  <= 1'b0;
      r_exp      <= '0;
      r_cnt      <= '0;
      r_r2       <= '0;
      r_xbar     <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mm_x     <= '0;
      r_mm_y     <= '0;
      r_mm_start <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= c_st_to_m_x;
            r_release  <= 1'b0;
            r_exp      <= exp;
            r_r2       <= r2;
            r_cnt      <= LOGE'(E_BITS - 1);
            r_mm_x     <= msg;
            r_mm_y     <= r2;
            r_mm_start <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        c_st_done: begin
          r_done  <= 1'b0;
          r_state <= c_st_idle;
        end
        default: begin
          if (!r_release) begin
            // Capture exactly once, on the first sampled mm_done of this op.
            if (mm_done) begin
              if (r_state == c_st_to_m_x) begin
                r_xbar <= mm_z;
              end else begin
                r_acc <= mm_z;
              end
              r_mm_start <= 1'b0;
              r_release  <= 1'b1;
            end
          end else if (!mm_done) begin
            r_release <= 1'b0;
            if (w_next_state == c_st_done) begin
              r_state  <= c_st_done;
              r_result <= r_acc;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_state    <= w_next_state;
              r_mm_x     <= w_next_x;
              r_mm_y     <= w_next_y;
              r_mm_start <= 1'b1;
              if (w_step && !w_last) begin
                r_cnt <= r_cnt - 1'b1;
                r_exp <= r_exp << 1;
              end
            end
          end
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign mm_x     = r_mm_x;
  assign mm_y     = r_mm_y;
  assign mm_start = r_mm_start;

endmodule

`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mod_exp_ctrl : randomized self-checking bench with a Montgomery mod_mul model
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mod_exp_ctrl;

  localparam int M = 239;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] msg;
  logic [7:0] exp;
  logic [7:0] r2;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] mm_x;
  logic [7:0] mm_y;
  logic       mm_start;
  logic [7:0] mm_z;
  logic       mm_done;

  int n_checks = 0;
  int n_fail   = 0;
  int rinv     = 0;
  int lat_max  = 2;
  int stall    = 0;

  mod_exp_ctrl #(.K(8), .E_BITS(8), .LOGE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg(msg), .exp(exp), .r2(r2),
    .busy(busy), .done(done), .result(result),
    .mm_x(mm_x), .mm_y(mm_y), .mm_start(mm_start), .mm_z(mm_z), .mm_done(mm_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic logic [7:0] mont(input logic [7:0] x, input logic [7:0] y);
    longint p;
    p = longint'(x) * longint'(y) * longint'(rinv);
    return 8'(p % M);
  endfunction

  function automatic int modpow(input int b, input int e);
    int r;
    r = 1 % M;
    for (int i = 0; i < e; i++) r = (r * b) % M;
    return r;
  endfunction

  // Multiplier model: random latency, mm_done held until mm_start drops plus 'stall' cycles.
  int mst, mcnt, mhold;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_done <= 1'b0;
      mm_z    <= '0;
      mst     <= 0;
      mcnt    <= 0;
      mhold   <= 0;
    end else begin
      case (mst)
        0: if (mm_start) begin
             mcnt <= $urandom_range(0, lat_max);
             mst  <= 1;
           end
        1: if (mcnt == 0) begin
             mm_done <= 1'b1;
             mm_z    <= mont(mm_x, mm_y);
             mhold   <= stall;
             mst     <= 2;
           end else begin
             mcnt <= mcnt - 1;
           end
        default: if (!mm_start) begin
             if (mhold == 0) begin
               mm_done <= 1'b0;
               mst     <= 0;
             end else begin
               mhold <= mhold - 1;
             end
           end
      endcase
    end
  end

  // Input values seen by the DUT at each active edge.
  logic       e_start, e_rstn;
  logic [7:0] e_msg, e_exp;
  initial begin
    e_start = 1'b0;
    e_rstn  = 1'b0;
    e_msg   = '0;
    e_exp   = '0;
  end
  always @(posedge clk) begin
    e_start = start;
    e_rstn  = rst_n;
    e_msg   = msg;
    e_exp   = exp;
  end

  // Reference model: run phase, expected result and op count; compared every cycle.
  int         ph = 0;
  int         exp_res = 0;
  int         exp_ops = 0;
  int         ops = 0;
  logic [7:0] m_result = '0;
  logic       prev_start = 1'b0;
  logic       prev_act = 1'b0;
  logic [7:0] px = '0, py = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ph         = 0;
      m_result   = '0;
      prev_start = 1'b0;
      prev_act   = 1'b0;
    end else begin
      if (ph == 0 && e_start && e_rstn) begin
        ph      = 1;
        exp_res = modpow(int'(e_msg), int'(e_exp));
        exp_ops = 3 + 8 + $countones(e_exp);
        ops     = 0;
      end else if (ph == 2) begin
        ph = 0;
      end
      if (mm_start && !prev_start) ops++;
      prev_start = mm_start;
      if (ph == 1 && done) begin
        chk("model_result", result, exp_res);
        chk("op_count", ops, exp_ops);
        chk("busy_at_done", busy, 0);
        m_result = 8'(exp_res);
        ph       = 2;
      end else begin
        chk("busy", busy, (ph == 1));
        chk("done", done, 0);
        chk("result_held", result, m_result);
      end
      if ((mm_start || mm_done) && prev_act) begin
        chk("mm_x_stable", mm_x, px);
        chk("mm_y_stable", mm_y, py);
      end
      prev_act = mm_start || mm_done;
      px       = mm_x;
      py       = mm_y;
    end
  end

  task automatic wait_done(input logic [7:0] lit, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout waiting for done, got 0, expected 1", nm);
    end else begin
      chk(nm, result, lit);
    end
  endtask

  task automatic wait_busy(input string nm);
    int n;
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, busy, 1);
  endtask

  task automatic run(input logic [7:0] m_, input logic [7:0] e_, input logic [7:0] lit,
                     input string nm);
    @(negedge clk);
    msg   = m_;
    exp   = e_;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lit, nm);
  endtask

  initial begin
    logic [7:0] rm, re;
    int n;
    for (int v = 1; v < M; v++) if (((256 * v) % M) == 1) rinv = v;
    rst_n = 1'b0;
    start = 1'b0;
    msg   = '0;
    exp   = '0;
    r2    = 8'd50;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_mm_start", mm_start, 0);
    chk("rst_mm_x", mm_x, 0);
    chk("rst_mm_y", mm_y, 0);
    rst_n = 1'b1;

    run(8'd5, 8'd3, 8'd125, "lit_5_3");
    run(8'd2, 8'd10, 8'd68, "lit_2_10");
    run(8'd238, 8'd2, 8'd1, "lit_238_2");
    run(8'd77, 8'd0, 8'd1, "lit_exp0");
    run(8'd0, 8'd5, 8'd0, "lit_msg0");

    for (int i = 0; i < 12; i++) begin
      lat_max = $urandom_range(0, 3);
      rm      = 8'($urandom_range(0, M - 1));
      re      = 8'($urandom_range(0, 255));
      run(rm, re, 8'(modpow(int'(rm), int'(re))), "rand_run");
    end

    lat_max = 1;
    stall   = 2;
    run(8'd5, 8'd3, 8'd125, "stall_5_3");
    run(8'd2, 8'd10, 8'd68, "stall_2_10");
    stall = 0;

    // Two back-to-back runs with start held; inputs disturbed while busy.
    @(negedge clk);
    msg   = 8'd2;
    exp   = 8'd10;
    start = 1'b1;
    @(negedge clk);
    wait_busy("held_busy1");
    msg = 8'd5;
    exp = 8'd3;
    wait_done(8'd68, "held_first");
    @(negedge clk);
    wait_busy("held_busy2");
    msg = 8'd77;
    exp = 8'd200;
    wait_done(8'd125, "held_second");
    start = 1'b0;

    // Reset during the first SQR op.
    @(negedge clk);
    msg   = 8'd5;
    exp   = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(ops == 3 && mm_start) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_sqr", ops, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mm_start", mm_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(8'd5, 8'd3, 8'd125, "after_reset");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
